seven_seg_scan: RTL

- Time-multiplexed scan controller for the 8-digit common-anode seven-segment display on the board.
- Sits directly upstream of the per-digit segment decoder. Each digit slot drives that decoder's 4-bit num and point inputs and asserts the matching active-low anode.
- Latches a 32-bit display word (8 hex nibbles) from the CPU/debug datapath and applies it tear-free at frame boundaries.
- Inserts a blanking gap between digits to suppress ghosting.

---
 rtl/seven_seg_scan_pkg.sv | 22 ++
 rtl/seven_seg_scan_if.sv | 25 ++
 rtl/seven_seg_lz_mask.sv | 23 ++
 rtl/seven_seg_scan.sv | 87 ++++++++
 4 files changed

// File: rtl/seven_seg_scan_pkg.sv
// Shared definitions for the 8-digit seven-segment scan controller.
// Digit count, anode encoding, slot states and the display word bundle.
package seven_seg_scan_pkg;

    localparam int NUM_DIGITS       = 8;
    localparam logic [7:0] ANODE_OFF = 8'hFF;

    localparam int DEF_SCAN_DIV     = 100000;
    localparam int DEF_BLANK_CYCLES = 1000;

    typedef enum logic {
        BLANK,
        SHOW
    } slot_t;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  point_mask;
        logic [7:0]  digit_en;
    } disp_t;

endpackage

// File: rtl/seven_seg_scan_if.sv
// Display bus between the CPU/debug datapath and the scan controller.
// The master side loads display words; the slave side drives the decoder.
interface seven_seg_scan_if;

    logic [31:0] data;
    logic        load;
    logic [7:0]  point_mask;
    logic [7:0]  digit_en;
    logic        lz_blank;
    logic [3:0]  num;
    logic        point;
    logic [7:0]  an;
    logic        frame_done;

    modport master (
        output data, load, point_mask, digit_en, lz_blank,
        input  num, point, an, frame_done
    );

    modport slave (
        input  data, load, point_mask, digit_en, lz_blank,
        output num, point, an, frame_done
    );

endinterface

// File: rtl/seven_seg_lz_mask.sv
// Leading-zero suppression mask for the active display word.
// A digit is suppressed when it and all digits above it are zero.
module seven_seg_lz_mask
    import seven_seg_scan_pkg::*;
(
    input  logic [31:0]           data,
    input  logic [NUM_DIGITS-1:0] point_mask,
    input  logic                  lz_blank,
    output logic [NUM_DIGITS-1:0] suppress
);

    always_comb begin : scan
        logic zero;
        zero     = 1'b1;
        suppress = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero = zero && (data[4*k +: 4] == 4'h0);
            // a lit point keeps its digit, and digit 0 always shows
            suppress[k] = lz_blank && zero && !point_mask[k] && (k != 0);
        end
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed scan controller for an 8-digit common-anode display.
// Display words are double-buffered and swapped only at frame boundaries.
module seven_seg_scan
    import seven_seg_scan_pkg::*;
#(
    parameter int SCAN_DIV     = DEF_SCAN_DIV,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input logic            clk,
    input logic            rst_n,
    seven_seg_scan_if.slave bus
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);

    logic [CW-1:0]         cnt;
    logic [2:0]            idx;
    disp_t                 pending;
    disp_t                 active;
    disp_t                 incoming;
    logic                  pending_flag;
    logic                  slot_end;
    logic                  boundary;
    slot_t                 slot;
    logic [NUM_DIGITS-1:0] suppress;
    logic [NUM_DIGITS-1:0] visible;

    assign incoming = {bus.data, bus.point_mask, bus.digit_en};
    assign slot_end = (cnt == CNT_LAST);
    assign boundary = slot_end && (idx == 3'd7);
    assign slot     = (cnt < CNT_SHOW) ? BLANK : SHOW;

    seven_seg_lz_mask u_lz_mask (
        .data       (active.data),
        .point_mask (active.point_mask),
        .lz_blank   (bus.lz_blank),
        .suppress   (suppress)
    );

    assign visible = active.digit_en & ~suppress;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt            <= '0;
            idx            <= '0;
            pending        <= '0;
            active         <= '0;
            pending_flag   <= 1'b0;
            bus.num        <= 4'h0;
            bus.point      <= 1'b0;
            bus.an         <= ANODE_OFF;
            bus.frame_done <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx <= idx + 3'd1;
            end
            bus.frame_done <= boundary;

            // a load on the boundary itself bypasses the pending buffer
            if (boundary) begin
                pending_flag <= 1'b0;
                if (bus.load) begin
                    active <= incoming;
                end else if (pending_flag) begin
                    active <= pending;
                end
            end else if (bus.load) begin
                pending      <= incoming;
                pending_flag <= 1'b1;
            end

            if (cnt == '0) begin
                bus.num   <= active.data[{idx, 2'b00} +: 4];
                bus.point <= active.point_mask[idx];
            end

            unique case (slot)
                BLANK: bus.an <= ANODE_OFF;
                SHOW:  bus.an <= visible[idx] ? ~(8'h01 << idx) : ANODE_OFF;
            endcase
        end
    end

endmodule
